// File: rtl/key_entry_capture_if.sv
// key_entry_capture_if: key/switch inputs and assembled-entry outputs of key_entry_capture.
// Latency: none, wiring only.
// Backpressure: none; all signals are levels or single-cycle strobes.
interface key_entry_capture_if #(
  parameter int NIBBLES = 4
);
  logic [1:0]           KEY;    // raw push-buttons, active-low; [0]=enter, [1]=clear
  logic [3:0]           SW;     // nibble captured on enter
  logic [4*NIBBLES-1:0] VALUE;  // assembled value, newest nibble in [3:0]
  logic [3:0]           COUNT;  // nibbles captured so far
  logic                 FULL;   // high while COUNT==NIBBLES
  logic                 VALID;  // one-cycle strobe on entry completion
  logic                 ERR;    // rejected-digit flag

  // Board side: drives keys and switches, watches the display outputs.
  modport master (
    output KEY, SW,
    input  VALUE, COUNT, FULL, VALID, ERR
  );

  // Capture block side.
  modport slave (
    input  KEY, SW,
    output VALUE, COUNT, FULL, VALID, ERR
  );
endinterface

// File: rtl/key_entry_capture.sv
// key_entry_capture: debounces KEY[1:0] and assembles a hex entry nibble by nibble from SW[3:0].
// Latency: capture lands DEBOUNCE_CYCLES+2 edges after KEY is first sampled low; all outputs registered.
// Backpressure: none; enter presses in FULL are ignored until a clear. Optional BCD check: KEY_ENTRY_BCD_EN.
module key_entry_capture #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NIBBLES         = 4
) (
  input  logic               CLK,
  input  logic               RST,
  key_entry_capture_if.slave bus
);

  localparam int             CW        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
  localparam int             VW        = 4 * NIBBLES;
  localparam logic [3:0]     COUNT_MAX = 4'(NIBBLES);

  typedef enum logic {
    ST_ENTRY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Key conditioning
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_flush;   // fills with 1s once the synchroniser holds real samples
  logic [1:0]    r_armed;   // key has been seen released since reset
  logic [1:0]    r_deb;     // debounced level, 1 = released
  logic [CW-1:0] r_cnt [2];
  logic [1:0]    w_fall;
  logic [1:0]    w_press;
  logic          w_enter;
  logic          w_clear;

  // Entry state
  state_t        r_state;
  state_t        w_state_nxt;
  logic [VW-1:0] r_value;
  logic [3:0]    r_count;
  logic          r_full;
  logic          r_valid;
  logic          r_err;
  logic [VW-1:0] w_value_nxt;
  logic [VW-1:0] w_value_shift;
  logic [3:0]    w_count_nxt;
  logic [3:0]    w_count_inc;
  logic          w_full_nxt;
  logic          w_valid_nxt;
  logic          w_err_nxt;
  logic          w_last;
  logic          w_digit_ok;

  // Two-flop synchroniser and arming: a key held down through reset must be
  // released once before its presses count, so no event follows reset release.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1 <= 2'b11;
      r_sync2 <= 2'b11;
      r_flush <= 2'b00;
      r_armed <= 2'b00;
    end else begin
      r_sync1 <= bus.KEY;
      r_sync2 <= r_sync1;
      r_flush <= {r_flush[0], 1'b1};
      r_armed <= r_armed | ({2{r_flush[1]}} & r_sync2);
    end
  end

  // Per-key debounce: accept a new level after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_deb    <= 2'b11;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (r_sync2[k] == r_deb[k]) begin
          r_cnt[k] <= '0;
        end else if (r_cnt[k] == CNT_MAX) begin
          r_deb[k] <= r_sync2[k];
          r_cnt[k] <= '0;
        end else begin
          r_cnt[k] <= r_cnt[k] + CNT_ONE;
        end
      end
    end
  end

  // Press events fire in the cycle the debounced level is about to fall, so the
  // capture registers update on the same edge as the debounced level.
  assign w_fall[0] = r_deb[0] & ~r_sync2[0] & (r_cnt[0] == CNT_MAX);
  assign w_fall[1] = r_deb[1] & ~r_sync2[1] & (r_cnt[1] == CNT_MAX);
  assign w_press   = w_fall & r_armed;
  assign w_enter   = w_press[0];
  assign w_clear   = w_press[1];

`ifdef KEY_ENTRY_BCD_EN
  assign w_digit_ok = (bus.SW <= 4'd9);
`else
  assign w_digit_ok = 1'b1;
`endif

  // Oldest nibble falls off the top; a single-nibble entry just takes SW.
  if (NIBBLES > 1) begin : g_shift
    assign w_value_shift = {r_value[VW-5:0], bus.SW};
  end else begin : g_single
    assign w_value_shift = bus.SW;
  end

  assign w_count_inc = r_count + 4'd1;
  assign w_last      = (w_count_inc == COUNT_MAX);

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_ENTRY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: clear dominates; the accepted final digit moves to FULL.
  always_comb begin
    w_state_nxt = r_state;
    if (w_clear) begin
      w_state_nxt = ST_ENTRY;
    end else if ((r_state == ST_ENTRY) && w_enter && w_digit_ok && w_last) begin
      w_state_nxt = ST_FULL;
    end
  end

  // Output next-values: shift on accepted digit, wipe on clear, hold otherwise.
  always_comb begin
    w_value_nxt = r_value;
    w_count_nxt = r_count;
    w_valid_nxt = 1'b0;
    w_err_nxt   = r_err;
    if (w_clear) begin
      w_value_nxt = '0;
      w_count_nxt = 4'd0;
      w_err_nxt   = 1'b0;
    end else if ((r_state == ST_ENTRY) && w_enter) begin
      if (w_digit_ok) begin
        w_value_nxt = w_value_shift;
        w_count_nxt = w_count_inc;
        w_valid_nxt = w_last;
        w_err_nxt   = 1'b0;
      end else begin
        w_err_nxt   = 1'b1;
      end
    end
    w_full_nxt = (w_state_nxt == ST_FULL);
  end

  // Output registers; with the BCD check disabled r_err can only ever be cleared.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_value <= '0;
      r_count <= 4'd0;
      r_full  <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_value <= w_value_nxt;
      r_count <= w_count_nxt;
      r_full  <= w_full_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign bus.VALUE = r_value;
  assign bus.COUNT = r_count;
  assign bus.FULL  = r_full;
  assign bus.VALID = r_valid;
  assign bus.ERR   = r_err;

endmodule

// File: doc/key_entry_capture.md
Name: key_entry_capture

Overview:
Input-side counterpart to the switch-to-HEX display blocks. It debounces the two board push-buttons and assembles a multi-digit hex value that the operator enters one nibble at a time from SW[3:0]. The assembled value, its digit count and a completion strobe feed the existing HEX/LEDR display logic, so the operator sees each digit as it is entered.

Parameters:
DEBOUNCE_CYCLES, 500000, number of consecutive stable samples before a key level is accepted (10 ms at 50 MHz); must be ≥1.
NIBBLES, 4, number of hex digits per entry; range 1..8.

Ports:
CLK  input  1  system clock, rising-edge.
RST  input  1  asynchronous, active-high reset.
KEY  input  2  raw push-buttons, active-low; KEY[0]=enter, KEY[1]=clear.
SW  input  4  nibble to capture on enter.
VALUE  output  4*NIBBLES  assembled value; most recently entered nibble in bits [3:0].
COUNT  output  4  number of nibbles captured so far, 0..NIBBLES.
FULL  output  1  level; high while COUNT==NIBBLES.
VALID  output  1  single-cycle strobe; entry completed.
ERR  output  1  level; rejected-digit flag (optional feature only, else tied 0).

Behaviour:
- Reset (async, RST=1): VALUE=0, COUNT=0, FULL=0, VALID=0, ERR=0, state=ENTRY, sync flops=1, debounced keys=released (1), debounce counters=0. Reset mid-debounce discards the pending press; no event follows release of RST.
- Sync: each KEY bit passes through two flops; the sync flops reset to 1.
- Debounce, per key: if the sync output equals the debounced level, counter=0. Otherwise counter increments; when it reaches DEBOUNCE_CYCLES-1 and the mismatch persists, the debounced level takes the new value and counter=0. A bounce back before that point clears the counter.
- Press event: a one-cycle internal pulse on a debounced 1→0 transition. Latency from the first rising edge that samples KEY low, with KEY held low: the event is high after exactly DEBOUNCE_CYCLES+2 edges. Release generates no event. A held key generates exactly one event.
- FSM states are ENTRY and FULL.
  - ENTRY + enter event: VALUE <= {VALUE[4*NIBBLES-5:0], SW[3:0]} (drop the oldest nibble, which is 0-filled), COUNT <= COUNT+1. If the new COUNT==NIBBLES, go to FULL; FULL=1 and VALID=1 in the same cycle that VALUE shows the final nibble.
  - FULL + enter event: ignored; VALUE, COUNT and FULL are held, and VALID stays 0.
  - Clear event in any state: VALUE=0, COUNT=0, FULL=0, ERR=0, state=ENTRY.
  - Enter and clear events in the same cycle: clear wins; no shift, no VALID.
- VALID is registered and never high for more than one cycle. It is high only on the ENTRY→FULL transition.
- SW is sampled only on the event cycle and is not synchronised; the operator sets the switches before pressing.
- All outputs are registered.

Optional Feature:
Macro KEY_ENTRY_BCD_EN.
- Defined: on an enter event in ENTRY with SW[3:0] > 9, the nibble is rejected: no shift, no COUNT change, and ERR is set to 1. ERR stays 1 until the next accepted digit or a clear event, either of which sets ERR=0. In FULL, the digit check is skipped because entry is ignored.
- Undefined: all values 0..F are accepted, and the ERR output is tied 0.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and NIBBLES=4.
1. RST pulse mid-operation, with KEY held low across release → all outputs 0, COUNT=0, and no event until KEY goes high, then low again and is held 6 edges.
2. KEY[0] low held for 6 edges with SW=4'hA → VALUE=16'h000A, COUNT=1 on edge 6. A second press ≥6 edges later with SW=3 → VALUE=16'h00A3, COUNT=2. Holding the key 100 cycles → only one capture.
3. KEY[0] bouncing (low 2, high 1, low 2, high 1), then held low → no capture until 4 consecutive stable samples; exactly one capture.
4. Enter 1, 2, 3, 4 → VALUE=16'h1234, COUNT=4, FULL=1, VALID high for exactly 1 cycle in the same cycle VALUE=16'h1234. A fifth press with SW=5 → VALUE unchanged, VALID stays 0.
5. KEY[0] and KEY[1] pressed on the same edge while COUNT=2 → VALUE=0, COUNT=0, FULL=0, no VALID; the next entry of 7 → VALUE=16'h0007.
6. With KEY_ENTRY_BCD_EN defined: enter SW=4'hC → ERR=1, VALUE and COUNT unchanged; enter 9 → ERR=0, VALUE=16'h0009. Without the macro: enter SW=4'hC → VALUE=16'h000C, ERR=0.
